// File: rtl/multiplier_8bits_arbiter.sv
// Two-requester front end for one shared 8x8 unsigned multiplier.
// IDLE accepts one operand pair, MUL computes it, HOLD presents the result until it is taken.

module multiplier_8bits_version4 (
  output logic [15:0] product,
  input  logic [7:0]  A,
  input  logic [7:0]  B
);
  logic [7:0][15:0] pp;

  genvar i;
  generate
    for (i = 0; i < 8; i++) begin : g_pp
      assign pp[i] = B[i] ? ({8'd0, A} << i) : 16'd0;
    end
  endgenerate

  always_comb begin
    product = '0;
    for (int k = 0; k < 8; k++) product = product + pp[k];
  end
endmodule

module multiplier_8bits_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [15:0] res_product,
  output logic        res_id,
  input  logic        res_ready,
  output logic        busy,
  output logic [7:0]  done_count
);
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       id;
  } op_t;

  state_t      state, nstate;
  op_t         op;
  logic        last;
  logic        gnt0, gnt1, accept;
  logic [15:0] mul_p;

  // On a tie, req0 wins unless round-robin is on and req0 was served last.
  assign gnt0 = req0_valid && (!req1_valid || !RR_EN || last);
  assign gnt1 = req1_valid && !gnt0;

  assign req0_ready = rst_n && (state == IDLE) && gnt0;
  assign req1_ready = rst_n && (state == IDLE) && gnt1;
  assign accept     = req0_ready || req1_ready;

  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  multiplier_8bits_version4 u_mul (
    .product (mul_p),
    .A       (op.a),
    .B       (op.b)
  );

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = MUL;
      MUL:     nstate = HOLD;
      HOLD:    if (res_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last        <= 1'b1;
      op          <= '0;
      res_product <= '0;
      res_id      <= 1'b0;
      done_count  <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        op   <= gnt1 ? op_t'{req1_a, req1_b, 1'b1} : op_t'{req0_a, req0_b, 1'b0};
        last <= gnt1;
      end
      if (state == MUL) begin
        res_product <= mul_p;
        res_id      <= op.id;
      end
      if (res_valid && res_ready) done_count <= done_count + 8'd1;
    end
  end
endmodule
